// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x-oversampled UART receiver (8N1) with one-clock result strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_frame #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 163
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge on rxs
    // START  | confirming the start bit at its midpoint
    // DATA   | sampling DBIT data bits, LSB first
    // PARITY | sampling the even-parity bit (parity build only)
    // STOP   | sampling the stop bit, then publishing the result

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BAUD_DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic [BW-1:0]   baud_cnt;
    logic            tick;
    logic [3:0]      s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shreg;
    logic [DBIT:0]   shift_cat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Free-running oversample divider; never cleared by the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            baud_cnt <= '0;
        else if (baud_cnt == B_LAST)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    assign tick      = (baud_cnt == B_LAST);
    assign shift_cat = {rxs, shreg};
    assign busy      = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            s          <= '0;
            n          <= '0;
            shreg      <= '0;
            d_out      <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
        end else begin
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == 4'd7) begin
                            s <= '0;
                            n <= '0;
                            state <= rxs ? IDLE : DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == 4'd15) begin
                            s     <= '0;
                            shreg <= shift_cat[DBIT:1];
                            if (n == N_LAST)
                                state <= PARITY;
                            else
                                n <= n + 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (s == 4'd15) begin
                            s       <= '0;
                            par_bad <= (rxs != ^shreg);
                            state   <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP) begin
                            d_out      <= shreg;
                            rx_done    <= rxs & ~par_bad;
                            frame_err  <= ~rxs;
                            parity_err <= par_bad;
                            state      <= IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign parity_err = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            shreg     <= '0;
            d_out     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == 4'd7) begin
                            s <= '0;
                            n <= '0;
                            state <= rxs ? IDLE : DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == 4'd15) begin
                            s     <= '0;
                            shreg <= shift_cat[DBIT:1];
                            if (n == N_LAST)
                                state <= STOP;
                            else
                                n <= n + 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP) begin
                            // A bad stop bit still publishes the byte, flagged as a framing error.
                            d_out     <= shreg;
                            rx_done   <= rxs;
                            frame_err <= ~rxs;
                            state     <= IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: frames are queued as (byte, stop ok, parity ok) and every
// strobe is checked against the queue head, plus d_out hold and latency checks.
module tb_uart_rx_frame;

`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int BD      = 4;
    localparam int BIT_CLK = 16 * BD;
    localparam int LAT     = (8 + 16 * 8 + 16 * PB + 16) * BD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx_frame #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(BD)) dut (
        .clk(clk), .reset(reset), .rx(rx), .d_out(d_out), .rx_done(rx_done),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         par_ok;
        int         t0;
    } frame_t;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    frame_t q[$];
    frame_t f_cmp;
    logic [7:0] d_last = 8'h00;
    logic   ev;
    logic   prev_ev = 1'b0;
    int     lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset) begin
            chk("reset_outputs", {24'd0, d_out, rx_done, frame_err, parity_err, busy}, 32'd0);
            prev_ev = 1'b0;
        end else begin
            ev = rx_done | frame_err | parity_err;
            if (ev) begin
                chk("pulse_width", {31'd0, prev_ev}, 32'd0);
                chk("done_vs_ferr", {31'd0, rx_done & frame_err}, 32'd0);
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {29'd0, rx_done, frame_err, parity_err}, 32'd0);
                end else begin
                    f_cmp = q.pop_front();
                    chk("d_out", d_out, f_cmp.data);
                    chk("rx_done", rx_done, f_cmp.stop_ok && f_cmp.par_ok);
                    chk("frame_err", frame_err, !f_cmp.stop_ok);
                    chk("parity_err", parity_err, !f_cmp.par_ok);
                    lat = cyc - f_cmp.t0;
                    chk("latency", (lat >= LAT - 1 && lat <= LAT + 5) ? LAT : lat, LAT);
                    d_last = f_cmp.data;
                end
            end else begin
                chk("d_out_hold", d_out, d_last);
            end
            prev_ev = ev;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_clk(BIT_CLK);
    endtask

    // A bad stop bit is held low only past its midpoint: the receiver re-arms on the
    // low line after the error, and the early release makes that re-arm a clean false start.
    task automatic send(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        frame_t f;
        f.data = d;
        f.stop_ok = stop_ok;
        f.par_ok = par_ok;
        f.t0 = cyc;
        q.push_back(f);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PB == 1) drive_bit((^d) ^ !par_ok);
        if (stop_ok) begin
            drive_bit(1'b1);
        end else begin
            rx = 1'b0;
            wait_clk(40);
            rx = 1'b1;
            wait_clk(2 * BIT_CLK - 40);
        end
    endtask

    logic [7:0] rb;
    bit         rs;
    bit         rp;
    int         gap;

    initial begin
        @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        wait_clk(5);
        chk("reset_d_out", d_out, 8'h00);
        chk("reset_busy", busy, 1'b0);
        reset = 1'b0;
        wait_clk(10);

        send(8'h01, 1, 1);
        chk("drain_01", q.size(), 0);
        chk("d_out_01", d_out, 8'h01);
        wait_clk(20);
        chk("busy_after_01", busy, 1'b0);

        send(8'hA5, 1, 1);
        chk("drain_a5", q.size(), 0);
        chk("d_out_a5", d_out, 8'hA5);
        send(8'h3C, 1, 1);
        chk("drain_3c", q.size(), 0);
        chk("d_out_3c", d_out, 8'h3C);
        wait_clk(30);

        rx = 1'b0;
        wait_clk(8);
        chk("busy_glitch_start", busy, 1'b1);
        wait_clk(8);
        rx = 1'b1;
        wait_clk(32);
        chk("busy_glitch_end", busy, 1'b0);
        chk("d_out_glitch", d_out, 8'h3C);
        wait_clk(BIT_CLK);

        send(8'h5A, 0, 1);
        chk("drain_5a", q.size(), 0);
        chk("d_out_5a", d_out, 8'h5A);
        chk("busy_after_5a", busy, 1'b0);

        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b1;
        wait_clk(BIT_CLK / 2);
        q.delete();
        d_last = 8'h00;
        reset = 1'b1;
        wait_clk(4);
        chk("d_out_reset_mid", d_out, 8'h00);
        reset = 1'b0;
        wait_clk(12 * BIT_CLK);
        chk("d_out_after_abort", d_out, 8'h00);
        send(8'h02, 1, 1);
        chk("drain_02", q.size(), 0);
        chk("d_out_02", d_out, 8'h02);
        wait_clk(BIT_CLK);

`ifdef UART_RX_PARITY_EN
        send(8'h03, 1, 0);
        chk("drain_par_bad", q.size(), 0);
        chk("d_out_par_bad", d_out, 8'h03);
        send(8'h03, 1, 1);
        chk("drain_par_good", q.size(), 0);
        send(8'h81, 0, 0);
        chk("drain_par_both", q.size(), 0);
`endif

        for (int k = 0; k < 30; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            rp = (PB == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            send(rb, rs, rp);
            chk("drain_rand", q.size(), 0);
            gap = $urandom_range(0, 2 * BIT_CLK);
            wait_clk(gap);
        end

        wait_clk(2 * BIT_CLK);
        chk("final_drain", q.size(), 0);
        chk("final_busy", busy, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
